// File: rtl/filter_unpad_if.sv
// Pixel stream bundle between the filter output and filter_unpad.
// Coordinate outputs oX/oY exist only when FILTER_UNPAD_COORD_EN is defined.
interface filter_unpad_if;
    logic        iValid;
    logic [23:0] iData;
    logic [23:0] oData;
    logic        oValid;
    logic        oDone;
`ifdef FILTER_UNPAD_COORD_EN
    logic [31:0] oX;
    logic [31:0] oY;
`endif

    modport master (
        output iValid, iData,
        input  oData, oValid, oDone
`ifdef FILTER_UNPAD_COORD_EN
        , input oX, oY
`endif
    );

    modport slave (
        input  iValid, iData,
        output oData, oValid, oDone
`ifdef FILTER_UNPAD_COORD_EN
        , output oX, oY
`endif
    );
endinterface

// File: rtl/filter_unpad.sv
// Drops the zero border around each padded frame and forwards interior pixels,
// pulsing oDone after the last padded pixel. Optional oX/oY via FILTER_UNPAD_COORD_EN.
module filter_unpad #(
    parameter int unsigned width      = 320,
    parameter int unsigned height     = 240,
    parameter int unsigned kernelSize = 7
) (
    input  logic          clk,
    input  logic          reset,
    filter_unpad_if.slave bus
);
    localparam int unsigned B  = (kernelSize - 1) / 2;
    localparam int unsigned PW = width + 2 * B;
    localparam int unsigned PH = height + 2 * B;

    typedef enum logic [1:0] {S_TOP, S_BODY, S_BOTTOM} state_t;

    // With no border the frame starts directly in the body region.
    localparam state_t START_STATE = (B > 0) ? S_TOP : S_BODY;

    state_t      state;
    state_t      next_state;
    logic [31:0] col;
    logic [31:0] row;
    logic [31:0] next_row;
    logic        last_col;
    logic        pass;

    // Next state is derived from the next row value so that empty border regions
    // (kernelSize 1) are skipped without special-case transitions.
    always_comb begin
        last_col   = (col == PW - 1);
        pass       = (state == S_BODY) && (col >= B) && (col < B + width);
        next_row   = (row == PH - 1) ? '0 : row + 32'd1;
        next_state = S_BOTTOM;
        if (next_row < B)
            next_state = S_TOP;
        else if (next_row < B + height)
            next_state = S_BODY;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= START_STATE;
            col        <= '0;
            row        <= '0;
            bus.oData  <= '0;
            bus.oValid <= 1'b0;
            bus.oDone  <= 1'b0;
`ifdef FILTER_UNPAD_COORD_EN
            bus.oX     <= '0;
            bus.oY     <= '0;
`endif
        end else begin
            bus.oValid <= 1'b0;
            bus.oDone  <= 1'b0;
            if (bus.iValid) begin
                if (pass) begin
                    bus.oData  <= bus.iData;
                    bus.oValid <= 1'b1;
`ifdef FILTER_UNPAD_COORD_EN
                    bus.oX     <= col - B;
                    bus.oY     <= row - B;
`endif
                end
                if (last_col) begin
                    col       <= '0;
                    row       <= next_row;
                    state     <= next_state;
                    bus.oDone <= (row == PH - 1);
                end else begin
                    col <= col + 32'd1;
                end
            end
        end
    end
endmodule
